// File: rtl/stream_mux_rr.sv
// stream_mux_rr: NUM_CH-way valid/ready mux, fixed select or round-robin, registered output stage.
// Optional SVA checks are compiled in with `define STREAM_MUX_ASSERT_EN.
module stream_mux_rr #(
  parameter int NUM_CH = 4,
  parameter int DATA_W = 8,
  parameter int SEL_W  = $clog2(NUM_CH)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_CH*DATA_W-1:0] in_data,
  input  logic [NUM_CH-1:0]        in_valid,
  output logic [NUM_CH-1:0]        in_ready,
  input  logic                     mode_rr,
  input  logic [SEL_W-1:0]         sel,
  output logic [DATA_W-1:0]        out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [SEL_W-1:0]         grant_idx,
  output logic                     sel_err
);
  logic [DATA_W-1:0] out_data_q, out_data_d, sel_data;
  logic [SEL_W-1:0]  grant_q, grant_d, ptr_q, ptr_d, cand;
  logic              out_valid_q, out_valid_d, sel_err_q, sel_err_d;
  logic              load, has_cand, xfer, sel_oob;
  assign load    = !out_valid_q || out_ready;
  assign sel_oob = int'(sel) >= NUM_CH;
  // Descending search so the channel closest after ptr is assigned last and wins.
  always_comb begin
    cand     = sel;
    has_cand = !mode_rr && !sel_oob;
    if (mode_rr)
      for (int k = NUM_CH; k >= 1; k--)
        if (in_valid[(int'(ptr_q) + k) % NUM_CH]) begin
          cand     = SEL_W'((int'(ptr_q) + k) % NUM_CH);
          has_cand = 1'b1;
        end
  end
  always_comb begin
    in_ready = '0;
    sel_data = '0;
    for (int i = 0; i < NUM_CH; i++)
      if (load && has_cand && int'(cand) == i) begin
        in_ready[i] = 1'b1;
        sel_data    = in_data[i*DATA_W +: DATA_W];
      end
  end
  assign xfer = |(in_ready & in_valid);
  always_comb begin
    out_valid_d = load ? xfer : out_valid_q;
    out_data_d  = xfer ? sel_data : out_data_q;
    grant_d     = xfer ? cand : grant_q;
    ptr_d       = (xfer && mode_rr) ? cand : ptr_q;
    sel_err_d   = sel_err_q || (!mode_rr && sel_oob && |in_valid);
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      grant_q     <= '0;
      ptr_q       <= SEL_W'(NUM_CH - 1);
      sel_err_q   <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      grant_q     <= grant_d;
      ptr_q       <= ptr_d;
      sel_err_q   <= sel_err_d;
    end
  end
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign grant_idx = grant_q;
  assign sel_err   = sel_err_q;
`ifdef STREAM_MUX_ASSERT_EN
  // Per-channel count of grants given to others while this channel waits in RR mode.
  logic [4:0] wait_q [NUM_CH];
  always_ff @(posedge clk)
    for (int i = 0; i < NUM_CH; i++)
      wait_q[i] <= (!rst_n || !mode_rr || !in_valid[i] || (xfer && int'(cand) == i)) ? 5'd0 : wait_q[i] + 5'(xfer);
  a_hold: assert property (@(posedge clk) disable iff (!rst_n)
    out_valid_q && !out_ready |=> $stable(out_data_q) && $stable(grant_q) && out_valid_q)
    else $error("stream_mux_rr: output changed while stalled");
  a_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(in_ready))
    else $error("stream_mux_rr: more than one in_ready asserted");
  a_data: assert property (@(posedge clk) disable iff (!rst_n) xfer |=> out_data_q == $past(sel_data))
    else $error("stream_mux_rr: out_data does not match transferred word");
  for (genvar g = 0; g < NUM_CH; g++) begin : g_starve
    a_starve: assert property (@(posedge clk) disable iff (!rst_n) wait_q[g] < 5'(NUM_CH))
      else $error("stream_mux_rr: channel %0d starved", g);
  end
`endif
endmodule

// File: tb/tb_stream_mux_rr.sv
// tb_stream_mux_rr: directed checks of stream_mux_rr, NUM_CH=4 and NUM_CH=3 builds.
module tb_stream_mux_rr;
  logic        clk = 1'b0;
  logic        rst_n, mode_rr, out_ready, out_valid, sel_err;
  logic [31:0] in_data;
  logic [3:0]  in_valid, in_ready;
  logic [1:0]  sel, grant_idx;
  logic [7:0]  out_data;
  logic        b_rst_n, b_mode_rr, b_out_ready, b_out_valid, b_sel_err;
  logic [23:0] b_in_data;
  logic [2:0]  b_in_valid, b_in_ready;
  logic [1:0]  b_sel, b_grant_idx;
  logic [7:0]  b_out_data;
  int          n_vec = 0, n_err = 0;
  logic [7:0]  rr_exp [6] = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h10, 8'h11};
  always #5 clk = ~clk;
  stream_mux_rr #(.NUM_CH(4), .DATA_W(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .mode_rr(mode_rr), .sel(sel), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .grant_idx(grant_idx), .sel_err(sel_err));
  stream_mux_rr #(.NUM_CH(3), .DATA_W(8)) u_dut3 (
    .clk(clk), .rst_n(b_rst_n), .in_data(b_in_data), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .mode_rr(b_mode_rr), .sel(b_sel), .out_data(b_out_data), .out_valid(b_out_valid),
    .out_ready(b_out_ready), .grant_idx(b_grant_idx), .sel_err(b_sel_err));
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  initial begin
    rst_n = 1'b0; mode_rr = 1'b0; sel = 2'd0; in_data = '0; in_valid = '0; out_ready = 1'b0;
    b_rst_n = 1'b0; b_mode_rr = 1'b0; b_sel = 2'd0; b_in_data = '0; b_in_valid = '0; b_out_ready = 1'b0;
    tick; tick;
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_data", 32'(out_data), 0);
    chk("rst_grant", 32'(grant_idx), 0);
    chk("rst_selerr", 32'(sel_err), 0);
    rst_n = 1'b1;
    mode_rr = 1'b0; sel = 2'd2; in_data = 32'h07060504; in_valid = 4'hF; out_ready = 1'b1;
    #1 chk("fix_ready", 32'(in_ready), 32'b0100);
    tick;
    chk("fix_data", 32'(out_data), 32'h06);
    chk("fix_grant", 32'(grant_idx), 2);
    chk("fix_valid", 32'(out_valid), 1);
    mode_rr = 1'b1; in_data = 32'h13121110;
    #1 chk("rr_first_ready", 32'(in_ready), 32'b0001);
    for (int i = 0; i < 6; i++) begin
      tick;
      chk($sformatf("rr_seq%0d", i), 32'(out_data), 32'(rr_exp[i]));
    end
    chk("rr_seq_grant", 32'(grant_idx), 1);
    out_ready = 1'b0;
    #1 chk("stall_ready0", 32'(in_ready), 0);
    for (int i = 0; i < 3; i++) begin
      tick;
      chk($sformatf("stall_data%0d", i), 32'(out_data), 32'h11);
      chk($sformatf("stall_valid%0d", i), 32'(out_valid), 1);
      chk($sformatf("stall_ready%0d", i), 32'(in_ready), 0);
    end
    out_ready = 1'b1;
    #1 chk("release_ready", 32'(in_ready), 32'b0100);
    tick;
    chk("release_data", 32'(out_data), 32'h12);
    chk("release_valid", 32'(out_valid), 1);
    mode_rr = 1'b0; sel = 2'd0; in_data = 32'h00000055; in_valid = 4'b0001;
    tick;
    chk("hold55_data", 32'(out_data), 32'h55);
    out_ready = 1'b0; in_valid = 4'b0000;
    tick;
    chk("hold55_stall", 32'(out_data), 32'h55);
    chk("hold55_valid", 32'(out_valid), 1);
    rst_n = 1'b0;
    tick;
    chk("rst2_valid", 32'(out_valid), 0);
    chk("rst2_data", 32'(out_data), 0);
    chk("rst2_grant", 32'(grant_idx), 0);
    rst_n = 1'b1; mode_rr = 1'b1; in_data = 32'h13121110; in_valid = 4'hF; out_ready = 1'b1;
    #1 chk("rst2_rr_ready", 32'(in_ready), 32'b0001);
    tick;
    chk("rst2_rr_grant0", 32'(grant_idx), 0);
    chk("rst2_rr_data0", 32'(out_data), 32'h10);
    tick;
    chk("rst2_rr_grant1", 32'(grant_idx), 1);
    in_data = 32'h33223120; in_valid = 4'b1010;
    #1 chk("skip_ready3", 32'(in_ready), 32'b1000);
    tick;
    chk("skip_grant3", 32'(grant_idx), 3);
    chk("skip_data3", 32'(out_data), 32'h33);
    chk("wrap_ready1", 32'(in_ready), 32'b0010);
    tick;
    chk("wrap_grant1", 32'(grant_idx), 1);
    chk("wrap_data1", 32'(out_data), 32'h31);
    tick;
    chk("wrap_grant3", 32'(grant_idx), 3);
    in_valid = 4'b0000;
    tick;
    chk("idle_valid", 32'(out_valid), 0);
    chk("idle_data_hold", 32'(out_data), 32'h33);
    chk("idle_grant_hold", 32'(grant_idx), 3);
    chk("pow2_selerr", 32'(sel_err), 0);
    b_rst_n = 1'b1; b_sel = 2'd3; b_in_data = 24'h030201; b_in_valid = 3'b000; b_out_ready = 1'b1;
    tick;
    chk("n3_noval_selerr", 32'(b_sel_err), 0);
    b_in_valid = 3'b001;
    #1 chk("n3_oob_ready", 32'(b_in_ready), 0);
    tick;
    chk("n3_oob_valid", 32'(b_out_valid), 0);
    chk("n3_oob_selerr", 32'(b_sel_err), 1);
    b_sel = 2'd0; b_in_valid = 3'b000;
    tick;
    chk("n3_sticky", 32'(b_sel_err), 1);
    b_in_valid = 3'b001;
    tick;
    chk("n3_ch0_data", 32'(b_out_data), 32'h01);
    chk("n3_ch0_sticky", 32'(b_sel_err), 1);
    b_rst_n = 1'b0;
    tick;
    chk("n3_rst_selerr", 32'(b_sel_err), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
